max_stream_tracker: RTL and testbench



---
 rtl/max_pkg.sv | 14 +
 rtl/max_digit_cmp.sv | 13 +
 rtl/max_stream_tracker.sv | 136 +++++++++++++
 tb/tb_max_stream_tracker.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/max_pkg.sv
// Shared types and sizing helpers for the partitioned max datapath.
package max_pkg;
  localparam int DIGIT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    EMIT = 2'd2
  } state_e;

  function automatic int num_digits(input int width);
    return width / DIGIT_W;
  endfunction
endpackage

// File: rtl/max_digit_cmp.sv
// 2-bit digit magnitude compare; same greater/less terms as the combinational max slices.
module max_digit_cmp (
  input  logic [1:0] c,
  input  logic [1:0] m,
  output logic       gt,
  output logic       lt
);
  logic hi_eq;

  assign hi_eq = ~(c[1] ^ m[1]);
  assign gt    = (c[1] & ~m[1]) | (hi_eq & c[0] & ~m[0]);
  assign lt    = (m[1] & ~c[1]) | (hi_eq & m[0] & ~c[0]);
endmodule

// File: rtl/max_stream_tracker.sv
// Sequential running-maximum over a framed operand stream, one 2-bit digit compared per cycle.
// Define MAX_ARGIDX_EN to track and emit the index of the winning word (out_idx).
module max_stream_tracker #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
`ifdef MAX_ARGIDX_EN
  output logic [CNT_W-1:0] out_idx,
`endif
  output logic [CNT_W-1:0] out_count
);
  import max_pkg::*;

  localparam int D     = num_digits(WIDTH);
  localparam int PTR_W = (D > 1) ? $clog2(D) : 1;

  state_e                          state_q, state_d;
  logic                            first_q;
  logic                            last_q;
  logic [WIDTH-1:0]                max_q, cand_q;
  logic [CNT_W-1:0]                count_q;
  logic [PTR_W-1:0]                dptr_q;
  logic                            decided_q, dec_gt_q;
  logic [D-1:0][DIGIT_W-1:0]       cand_dig, max_dig;
  logic                            dig_gt, dig_lt;
  logic                            accept, cmp_done, fin_gt;
`ifdef MAX_ARGIDX_EN
  logic [CNT_W-1:0]                idx_q, cand_idx_q;
`endif

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign out_valid = (state_q == EMIT);
  assign accept    = in_valid & in_ready;

  assign cand_dig = cand_q;
  assign max_dig  = max_q;

  max_digit_cmp u_dcmp (
    .c  (cand_dig[dptr_q]),
    .m  (max_dig[dptr_q]),
    .gt (dig_gt),
    .lt (dig_lt)
  );

  assign cmp_done = (state_q == CMP) && (dptr_q == '0);
  // The first non-equal digit (MSB side) wins; an all-equal compare is a tie and keeps the stored word.
  assign fin_gt   = decided_q ? dec_gt_q : dig_gt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) begin
        if (first_q) state_d = in_last ? EMIT : IDLE;
        else         state_d = CMP;
      end
      CMP:  if (dptr_q == '0) state_d = last_q ? EMIT : IDLE;
      EMIT: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q   <= 1'b1;
      last_q    <= 1'b0;
      max_q     <= '0;
      cand_q    <= '0;
      count_q   <= '0;
      dptr_q    <= '0;
      decided_q <= 1'b0;
      dec_gt_q  <= 1'b0;
`ifdef MAX_ARGIDX_EN
      idx_q      <= '0;
      cand_idx_q <= '0;
`endif
    end else begin
      if (accept) begin
        if (first_q) begin
          first_q <= 1'b0;
          max_q   <= in_data;
          count_q <= CNT_W'(1);
`ifdef MAX_ARGIDX_EN
          idx_q   <= '0;
`endif
        end else begin
          cand_q    <= in_data;
          count_q   <= count_q + CNT_W'(1);
          last_q    <= in_last;
          dptr_q    <= PTR_W'(D - 1);
          decided_q <= 1'b0;
          dec_gt_q  <= 1'b0;
`ifdef MAX_ARGIDX_EN
          cand_idx_q <= count_q;
`endif
        end
      end

      if (state_q == CMP) begin
        if (!decided_q && (dig_gt || dig_lt)) begin
          decided_q <= 1'b1;
          dec_gt_q  <= dig_gt;
        end
        if (!cmp_done) dptr_q <= dptr_q - PTR_W'(1);
      end

      if (cmp_done && fin_gt) begin
        max_q <= cand_q;
`ifdef MAX_ARGIDX_EN
        idx_q <= cand_idx_q;
`endif
      end

      if (state_q == EMIT && out_ready) first_q <= 1'b1;
    end
  end

  assign out_max   = max_q;
  assign out_count = count_q;
`ifdef MAX_ARGIDX_EN
  assign out_idx   = idx_q;
`endif
endmodule

// File: tb/tb_max_stream_tracker.sv
// Directed bench for max_stream_tracker (WIDTH=8, CNT_W=8); out_idx checks follow MAX_ARGIDX_EN.
module tb_max_stream_tracker;
  logic       clk, rst;
  logic       in_valid, in_ready, in_last;
  logic [7:0] in_data;
  logic       out_valid, out_ready;
  logic [7:0] out_max, out_count;
`ifdef MAX_ARGIDX_EN
  logic [7:0] out_idx;
`endif

  int n_chk = 0;
  int n_err = 0;

  max_stream_tracker #(.WIDTH(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
`ifdef MAX_ARGIDX_EN
    .out_idx   (out_idx),
`endif
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Waits (bounded) for in_ready, returns the number of negedges spent waiting, then transfers one word.
  task automatic send(input logic [7:0] d, input logic l, output int waited);
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 50) chk("send_timeout", 0, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'hxx;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      if (!out_valid) n++;
    end
    if (n >= 50) chk("valid_timeout", 0, 1);
  endtask

  task automatic take_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("hs_in_ready", in_ready, 1);
    chk("hs_out_valid", out_valid, 0);
  endtask

  initial begin
    int w, n;
    logic stable;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_max", out_max, 0);
    chk("rst_out_count", out_count, 0);
`ifdef MAX_ARGIDX_EN
    chk("rst_out_idx", out_idx, 0);
`endif
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);

    // Frame 0x12, 0x7F, 0x40(last)
    send(8'h12, 1'b0, w);
    chk("f1_w0_wait", w, 0);
    send(8'h7F, 1'b0, w);
    chk("f1_w1_wait", w, 0);
    send(8'h40, 1'b1, w);
    chk("f1_w2_wait", w, 4);
    wait_valid(n);
    chk("f1_lat", n, 4);
    chk("f1_max", out_max, 8'h7F);
    chk("f1_count", out_count, 3);
`ifdef MAX_ARGIDX_EN
    chk("f1_idx", out_idx, 1);
`endif
    take_result();

    // Single-word frame
    send(8'hA5, 1'b1, w);
    chk("f2_valid_next", out_valid, 1);
    @(negedge clk);
    chk("f2_max", out_max, 8'hA5);
    chk("f2_count", out_count, 1);
`ifdef MAX_ARGIDX_EN
    chk("f2_idx", out_idx, 0);
`endif
    take_result();

    // Tie keeps the earlier word
    send(8'h33, 1'b0, w);
    send(8'h33, 1'b1, w);
    wait_valid(n);
    chk("f3_valid", out_valid, 1);
    chk("f3_max", out_max, 8'h33);
    chk("f3_count", out_count, 2);
`ifdef MAX_ARGIDX_EN
    chk("f3_idx", out_idx, 0);
`endif
    take_result();

    // Difference only in the LSB digit, then backpressure
    send(8'h80, 1'b0, w);
    send(8'h81, 1'b1, w);
    wait_valid(n);
    chk("f4_lat", n, 4);
    chk("f4_max", out_max, 8'h81);
`ifdef MAX_ARGIDX_EN
    chk("f4_idx", out_idx, 1);
`endif
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!out_valid || in_ready || out_max !== 8'h81 || out_count !== 8'd2) stable = 1'b0;
    end
    chk("f4_bp_stable", stable, 1);
    take_result();

    // Reset during CMP of the second word aborts the frame
    send(8'h10, 1'b0, w);
    send(8'h20, 1'b1, w);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ab_out_valid", out_valid, 0);
    chk("ab_out_max", out_max, 0);
    chk("ab_out_count", out_count, 0);
    chk("ab_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    send(8'h05, 1'b1, w);
    chk("f5_wait", w, 0);
    wait_valid(n);
    chk("f5_lat", n, 0);
    chk("f5_max", out_max, 8'h05);
    chk("f5_count", out_count, 1);
`ifdef MAX_ARGIDX_EN
    chk("f5_idx", out_idx, 0);
`endif
    take_result();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
